// File: rtl/flag_cond_pkg.sv
// -----------------------------------------------------------------------------
// flag_cond_pkg
// Shared types for the flag / condition unit and the conditional-move logic:
//   - cond_e   : the 16 branch/jump condition codes
//   - flags_t  : architectural flag word, packed {o,c,s,z} (bit 3 .. bit 0)
//   - FLAG_*   : bit positions of each flag inside the 4-bit flag register
//   - state_t  : decision-holding FSM states
// -----------------------------------------------------------------------------
package flag_cond_pkg;

  localparam int FLAG_O = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,   // always
    COND_Z  = 4'd1,   // Z
    COND_NZ = 4'd2,   // !Z
    COND_C  = 4'd3,   // C
    COND_NC = 4'd4,   // !C
    COND_S  = 4'd5,   // S
    COND_NS = 4'd6,   // !S
    COND_O  = 4'd7,   // O
    COND_NO = 4'd8,   // !O
    COND_LT = 4'd9,   // signed less than
    COND_GE = 4'd10,  // signed greater or equal
    COND_LE = 4'd11,  // signed less or equal
    COND_GT = 4'd12,  // signed greater than
    COND_HI = 4'd13,  // C & !Z
    COND_LS = 4'd14,  // !C | Z
    COND_NV = 4'd15   // never
  } cond_e;

  // Field order matches the FLAG_* bit positions, so a 4-bit flag word can
  // be cast straight to this struct.
  typedef struct packed {
    logic o;
    logic c;
    logic s;
    logic z;
  } flags_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/flag_cond_if.sv
// -----------------------------------------------------------------------------
// flag_cond_if
// Request / decision handshake between the execute stage, the flag/condition
// unit and the fetch stage.
//   cond_valid/cond_code/cond_target -> request, cond_ready <- acceptance
//   jump_valid/jump_taken/jump_target -> decision, jump_ready <- consumption
// Modports:
//   slave  : the flag/condition unit
//   master : the requester / decision consumer (execute + fetch side)
// -----------------------------------------------------------------------------
interface flag_cond_if #(
  parameter int ADDR_BITS = 16,
  parameter int COND_BITS = 4
);

  logic                 cond_valid;
  logic [COND_BITS-1:0] cond_code;
  logic [ADDR_BITS-1:0] cond_target;
  logic                 cond_ready;

  logic                 jump_valid;
  logic                 jump_taken;
  logic [ADDR_BITS-1:0] jump_target;
  logic                 jump_ready;

  modport slave (
    input  cond_valid,
    input  cond_code,
    input  cond_target,
    output cond_ready,
    output jump_valid,
    output jump_taken,
    output jump_target,
    input  jump_ready
  );

  modport master (
    output cond_valid,
    output cond_code,
    output cond_target,
    input  cond_ready,
    input  jump_valid,
    input  jump_taken,
    input  jump_target,
    output jump_ready
  );

endinterface

// File: rtl/flag_cond_eval.sv
// -----------------------------------------------------------------------------
// flag_cond_eval
// Purely combinational condition evaluator, shared with the conditional-move
// logic.
// Ports:
//   flags : flag word to test (flags_t {o,c,s,z})
//   code  : condition code (cond_e)
//   taken : 1 when the condition holds for the given flags
// -----------------------------------------------------------------------------
module flag_cond_eval
  import flag_cond_pkg::*;
(
  input  flags_t flags,
  input  cond_e  code,
  output logic   taken
);

  logic lt;   // signed less-than: sign differs from the true sign when O set
  logic le;

  assign lt = flags.s ^ flags.o;
  assign le = lt | flags.z;

  always_comb begin
    taken = 1'b0;
    case (code)
      COND_AL: taken = 1'b1;
      COND_Z:  taken = flags.z;
      COND_NZ: taken = ~flags.z;
      COND_C:  taken = flags.c;
      COND_NC: taken = ~flags.c;
      COND_S:  taken = flags.s;
      COND_NS: taken = ~flags.s;
      COND_O:  taken = flags.o;
      COND_NO: taken = ~flags.o;
      COND_LT: taken = lt;
      COND_GE: taken = ~lt;
      COND_LE: taken = le;
      COND_GT: taken = ~le;
      COND_HI: taken = flags.c & ~flags.z;
      COND_LS: taken = ~flags.c | flags.z;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_cond_unit.sv
// -----------------------------------------------------------------------------
// flag_cond_unit
// Consumer end of the ALU flag interface. Latches O/C/S/Z into the
// architectural flag register, evaluates condition codes against the flags and
// hands a registered taken/target decision to fetch over valid/ready.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   alu_o/c/s/z        : ALU flags
//   flag_we            : load alu_* into the flag register
//   flag_save          : (FLAG_SHADOW_EN) copy flags into the shadow register
//   flag_restore       : (FLAG_SHADOW_EN) copy the shadow into the flags
//   bus (slave)        : request (cond_*) and decision (jump_*) handshake
//   flags              : current flag register {O,C,S,Z}
//
// Build option: define FLAG_SHADOW_EN to add the shadow flag register with
// its save/restore controls.
//
// Decision path: a request accepted in cycle N is evaluated against the
// flags as they will be after cycle N's update (bypass), and the decision is
// on jump_* from cycle N+1. A held decision is replaced in the same cycle it
// is consumed, giving one decision per cycle under continuous traffic.
// -----------------------------------------------------------------------------
module flag_cond_unit
  import flag_cond_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int COND_BITS = 4
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_o,
  input  logic        alu_c,
  input  logic        alu_s,
  input  logic        alu_z,
  input  logic        flag_we,
`ifdef FLAG_SHADOW_EN
  input  logic        flag_save,
  input  logic        flag_restore,
`endif
  flag_cond_if.slave  bus,
  output logic [3:0]  flags
);

  logic [3:0]           alu_flags;
  logic [3:0]           flags_reg;
  logic [3:0]           flags_next;
  flags_t               eval_flags;
  logic [COND_BITS-1:0] code_raw;
  cond_e                code;
  logic                 taken_eval;
  logic                 cond_ready_int;
  logic                 accept;

  state_t               state_reg;
  logic                 jump_valid_reg;
  logic                 jump_taken_reg;
  logic [ADDR_BITS-1:0] jump_target_reg;

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_O] = alu_o;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_S] = alu_s;
    alu_flags[FLAG_Z] = alu_z;
  end

  // ---------------------------------------------------------------------------
  // Flag register (and optional shadow). flags_next is also the bypass value
  // used to evaluate a request accepted in the same cycle.
  // ---------------------------------------------------------------------------
`ifdef FLAG_SHADOW_EN
  logic [3:0] shadow_reg;
  logic [3:0] shadow_next;

  always_comb begin
    flags_next = flags_reg;
    if (flag_restore) begin
      flags_next = shadow_reg;
    end else if (flag_we) begin
      flags_next = alu_flags;
    end
    // Save captures the pre-update flags, so save+restore swaps the two.
    shadow_next = flag_save ? flags_reg : shadow_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg  <= '0;
      shadow_reg <= '0;
    end else begin
      flags_reg  <= flags_next;
      shadow_reg <= shadow_next;
    end
  end
`else
  always_comb begin
    flags_next = flag_we ? alu_flags : flags_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= '0;
    end else begin
      flags_reg <= flags_next;
    end
  end
`endif

  assign flags = flags_reg;

  // ---------------------------------------------------------------------------
  // Condition evaluation
  // ---------------------------------------------------------------------------
  assign eval_flags = flags_t'(flags_next);
  assign code_raw   = bus.cond_code;
  assign code       = cond_e'(code_raw);

  flag_cond_eval u_eval (
    .flags (eval_flags),
    .code  (code),
    .taken (taken_eval)
  );

  // ---------------------------------------------------------------------------
  // Decision-holding FSM. Ready depends only on state and jump_ready so the
  // requester never sees a combinational loop through cond_valid.
  // ---------------------------------------------------------------------------
  assign cond_ready_int = (state_reg == ST_EMPTY) | bus.jump_ready;
  assign accept         = bus.cond_valid & cond_ready_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_EMPTY;
      jump_valid_reg  <= 1'b0;
      jump_taken_reg  <= 1'b0;
      jump_target_reg <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_reg       <= ST_FULL;
            jump_valid_reg  <= 1'b1;
            jump_taken_reg  <= taken_eval;
            jump_target_reg <= bus.cond_target;
          end
        end
        ST_FULL: begin
          if (bus.jump_ready) begin
            if (accept) begin
              // Held decision consumed and replaced in the same cycle.
              jump_taken_reg  <= taken_eval;
              jump_target_reg <= bus.cond_target;
            end else begin
              state_reg      <= ST_EMPTY;
              jump_valid_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg      <= ST_EMPTY;
          jump_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cond_ready  = cond_ready_int;
  assign bus.jump_valid  = jump_valid_reg;
  assign bus.jump_taken  = jump_taken_reg;
  assign bus.jump_target = jump_target_reg;

endmodule

// File: tb/tb_flag_cond_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_cond_unit
// Self-checking bench for flag_cond_unit: directed scenarios followed by a
// randomized run against a behavioural model. Inputs change 1 time unit after
// the rising edge; outputs are checked in the same window.
// Define FLAG_SHADOW_EN to also exercise the shadow flag register.
// -----------------------------------------------------------------------------
module tb_flag_cond_unit;

  logic       clk;
  logic       reset;
  logic       alu_o, alu_c, alu_s, alu_z;
  logic       flag_we;
`ifdef FLAG_SHADOW_EN
  logic       flag_save;
  logic       flag_restore;
`endif
  logic [3:0] flags;

  int total;
  int bad;

  flag_cond_if #(.ADDR_BITS(16), .COND_BITS(4)) bus ();

  flag_cond_unit #(.ADDR_BITS(16), .COND_BITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_o        (alu_o),
    .alu_c        (alu_c),
    .alu_s        (alu_s),
    .alu_z        (alu_z),
    .flag_we      (flag_we),
`ifdef FLAG_SHADOW_EN
    .flag_save    (flag_save),
    .flag_restore (flag_restore),
`endif
    .bus          (bus),
    .flags        (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Reference condition: codes pair up as (test, negated test) from 1..14.
  function automatic logic ref_cond(input int code, input logic [3:0] f);
    logic o, c, s, z, base;
    int   k;
    o = f[3]; c = f[2]; s = f[1]; z = f[0];
    if (code == 0)  return 1'b1;
    if (code == 15) return 1'b0;
    k = (code + 1) / 2;
    case (k)
      1: base = z;
      2: base = c;
      3: base = s;
      4: base = o;
      5: base = (s != o);
      6: base = (s != o) || z;
      default: base = c && !z;
    endcase
    return (code % 2 == 1) ? base : !base;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset           = 1'b0;
    {alu_o, alu_c, alu_s, alu_z} = 4'b0000;
    flag_we         = 1'b0;
`ifdef FLAG_SHADOW_EN
    flag_save       = 1'b0;
    flag_restore    = 1'b0;
`endif
    bus.cond_valid  = 1'b0;
    bus.cond_code   = 4'd0;
    bus.cond_target = 16'h0000;
    bus.jump_ready  = 1'b1;
  endtask

  task automatic load_flags(input logic [3:0] v);
    flag_we = 1'b1;
    {alu_o, alu_c, alu_s, alu_z} = v;
    tick();
    flag_we = 1'b0;
  endtask

  task automatic request(input int code, input logic [15:0] target);
    bus.cond_valid  = 1'b1;
    bus.cond_code   = 4'(code);
    bus.cond_target = target;
    tick();
    bus.cond_valid  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset          = 1'b1;
    bus.cond_valid = 1'b1;
    bus.cond_code  = 4'd0;
    bus.cond_target = 16'hFFFF;
    flag_we        = 1'b1;
    {alu_o, alu_c, alu_s, alu_z} = 4'b1111;
    bus.jump_ready = 1'b0;
    tick();
    tick();
    total++;
    if (flags !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: actual=%b required=0000", flags);
    end
    total++;
    if (bus.jump_valid !== 1'b0) begin
      bad++; $display("FAIL reset_jump_valid: actual=%b required=0", bus.jump_valid);
    end
    total++;
    if (bus.jump_target !== 16'h0000 || bus.jump_taken !== 1'b0) begin
      bad++; $display("FAIL reset_jump_outs: actual taken=%b target=%h required taken=0 target=0000",
                      bus.jump_taken, bus.jump_target);
    end
    drive_idle();
    bus.jump_ready = 1'b0;
    #1;
    total++;
    if (bus.cond_ready !== 1'b1) begin
      bad++; $display("FAIL reset_cond_ready: actual=%b required=1", bus.cond_ready);
    end
    $display("txn reset: flags=%b jump_valid=%b cond_ready=%b", flags, bus.jump_valid, bus.cond_ready);

    // Reset while a decision is held must drop jump_valid.
    request(0, 16'h1234);
    total++;
    if (bus.jump_valid !== 1'b1) begin
      bad++; $display("FAIL mid_reset_setup: actual jump_valid=%b required=1", bus.jump_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (bus.jump_valid !== 1'b0 || bus.jump_target !== 16'h0000) begin
      bad++; $display("FAIL mid_reset_drop: actual valid=%b target=%h required valid=0 target=0000",
                      bus.jump_valid, bus.jump_target);
    end
    $display("txn mid-handshake reset: jump_valid=%b", bus.jump_valid);
    bus.jump_ready = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_bypass();
    flag_we = 1'b1;
    {alu_o, alu_c, alu_s, alu_z} = 4'b0001;
    bus.jump_ready = 1'b1;
    request(1, 16'h0040);
    flag_we = 1'b0;
    total++;
    if (bus.jump_valid !== 1'b1 || bus.jump_taken !== 1'b1 || bus.jump_target !== 16'h0040) begin
      bad++; $display("FAIL bypass_decision: actual valid=%b taken=%b target=%h required valid=1 taken=1 target=0040",
                      bus.jump_valid, bus.jump_taken, bus.jump_target);
    end
    total++;
    if (flags !== 4'b0001) begin
      bad++; $display("FAIL bypass_flags: actual=%b required=0001", flags);
    end
    $display("txn bypass: taken=%b target=%h flags=%b", bus.jump_taken, bus.jump_target, flags);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_signed();
    int          codes [4] = '{9, 10, 12, 11};
    logic [3:0]  fl    [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001};
    logic        exp   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      load_flags(fl[i]);
      request(codes[i], 16'h0200 + 16'(i));
      total++;
      if (bus.jump_valid !== 1'b1 || bus.jump_taken !== exp[i]) begin
        bad++; $display("FAIL signed_code%0d: actual valid=%b taken=%b required valid=1 taken=%b",
                        codes[i], bus.jump_valid, bus.jump_taken, exp[i]);
      end
      $display("txn signed: flags=%b code=%0d taken=%b", fl[i], codes[i], bus.jump_taken);
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    load_flags(4'b0001);
    bus.jump_ready = 1'b0;
    request(1, 16'hAAAA);
    bus.cond_valid  = 1'b1;
    bus.cond_code   = 4'd15;
    bus.cond_target = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.cond_ready !== 1'b0) begin
        bad++; $display("FAIL bp_cond_ready%0d: actual=%b required=0", i, bus.cond_ready);
      end
      tick();
      total++;
      if (bus.jump_valid !== 1'b1 || bus.jump_taken !== 1'b1 || bus.jump_target !== 16'hAAAA) begin
        bad++; $display("FAIL bp_hold%0d: actual valid=%b taken=%b target=%h required valid=1 taken=1 target=aaaa",
                        i, bus.jump_valid, bus.jump_taken, bus.jump_target);
      end
      $display("txn backpressure hold %0d: target=%h", i, bus.jump_target);
    end
    bus.jump_ready = 1'b1;
    #1;
    total++;
    if (bus.cond_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release_ready: actual=%b required=1", bus.cond_ready);
    end
    tick();
    bus.cond_valid = 1'b0;
    total++;
    if (bus.jump_valid !== 1'b1 || bus.jump_taken !== 1'b0 || bus.jump_target !== 16'h5555) begin
      bad++; $display("FAIL bp_new_decision: actual valid=%b taken=%b target=%h required valid=1 taken=0 target=5555",
                      bus.jump_valid, bus.jump_taken, bus.jump_target);
    end
    $display("txn backpressure release: target=%h taken=%b", bus.jump_target, bus.jump_taken);
    tick();
    total++;
    if (bus.jump_valid !== 1'b0) begin
      bad++; $display("FAIL bp_drain: actual valid=%b required=0", bus.jump_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    bus.jump_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cond_valid  = 1'b1;
      bus.cond_code   = (i % 2 == 0) ? 4'd0 : 4'd15;
      bus.cond_target = 16'h0100 + 16'(i);
      tick();
      total++;
      if (bus.jump_valid !== 1'b1 || bus.jump_taken !== (i % 2 == 0) ||
          bus.jump_target !== 16'h0100 + 16'(i)) begin
        bad++; $display("FAIL stream%0d: actual valid=%b taken=%b target=%h required valid=1 taken=%b target=%h",
                        i, bus.jump_valid, bus.jump_taken, bus.jump_target,
                        (i % 2 == 0), 16'h0100 + 16'(i));
      end
      $display("txn stream %0d: taken=%b target=%h", i, bus.jump_taken, bus.jump_target);
    end
    bus.cond_valid = 1'b0;
    tick();
    total++;
    if (bus.jump_valid !== 1'b0) begin
      bad++; $display("FAIL stream_drain: actual valid=%b required=0", bus.jump_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
`ifdef FLAG_SHADOW_EN
  task automatic test_shadow();
    load_flags(4'b1010);
    flag_save = 1'b1; tick(); flag_save = 1'b0;
    load_flags(4'b0101);
    total++;
    if (flags !== 4'b0101) begin
      bad++; $display("FAIL shadow_load: actual=%b required=0101", flags);
    end
    flag_restore = 1'b1; tick(); flag_restore = 1'b0;
    total++;
    if (flags !== 4'b1010) begin
      bad++; $display("FAIL shadow_restore: actual=%b required=1010", flags);
    end
    $display("txn shadow restore: flags=%b", flags);
    load_flags(4'b0101);
    flag_save = 1'b1; flag_restore = 1'b1; flag_we = 1'b1;
    {alu_o, alu_c, alu_s, alu_z} = 4'b1111;
    tick();
    flag_save = 1'b0; flag_restore = 1'b0; flag_we = 1'b0;
    total++;
    if (flags !== 4'b1010) begin
      bad++; $display("FAIL shadow_swap_flags: actual=%b required=1010", flags);
    end
    flag_restore = 1'b1; tick(); flag_restore = 1'b0;
    total++;
    if (flags !== 4'b0101) begin
      bad++; $display("FAIL shadow_swap_shadow: actual=%b required=0101", flags);
    end
    $display("txn shadow swap: flags=%b", flags);
    // Restore coincident with a request: evaluation sees the restored Z=1.
    flag_restore = 1'b1; flag_we = 1'b1;
    {alu_o, alu_c, alu_s, alu_z} = 4'b0000;
    request(1, 16'h0777);
    flag_restore = 1'b0; flag_we = 1'b0;
    total++;
    if (bus.jump_taken !== 1'b1 || flags !== 4'b0101) begin
      bad++; $display("FAIL shadow_bypass: actual taken=%b flags=%b required taken=1 flags=0101",
                      bus.jump_taken, flags);
    end
    tick();
  endtask
`endif

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [3:0]  m_flags, m_shadow, alu_v, eff;
    logic        m_full, m_taken, acc, we, sv, rs;
    logic [15:0] m_target;
    int          code;
    reset = 1'b1; tick(); reset = 1'b0;
    m_flags = 4'b0; m_shadow = 4'b0; m_full = 1'b0; m_taken = 1'b0; m_target = 16'h0;
    for (int n = 0; n < 300; n++) begin
      reset           = ($urandom_range(0, 49) == 0);
      alu_v           = 4'($urandom_range(0, 15));
      {alu_o, alu_c, alu_s, alu_z} = alu_v;
      we              = ($urandom_range(0, 2) == 0);
      flag_we         = we;
      sv = 1'b0; rs = 1'b0;
`ifdef FLAG_SHADOW_EN
      sv              = ($urandom_range(0, 5) == 0);
      rs              = ($urandom_range(0, 5) == 0);
      flag_save       = sv;
      flag_restore    = rs;
`endif
      code            = int'($urandom_range(0, 15));
      bus.cond_valid  = ($urandom_range(0, 9) < 7);
      bus.cond_code   = 4'(code);
      bus.cond_target = 16'($urandom);
      bus.jump_ready  = ($urandom_range(0, 9) < 6);
      #1;
      total++;
      if (bus.cond_ready !== (!m_full || bus.jump_ready)) begin
        bad++; $display("FAIL rand_ready%0d: actual=%b required=%b", n, bus.cond_ready,
                        (!m_full || bus.jump_ready));
      end
      // Model update for this edge.
      if (reset) begin
        m_flags = 4'b0; m_shadow = 4'b0; m_full = 1'b0; m_taken = 1'b0; m_target = 16'h0;
      end else begin
        acc = bus.cond_valid && (!m_full || bus.jump_ready);
        eff = rs ? m_shadow : (we ? alu_v : m_flags);
        if (sv) m_shadow = m_flags;
        if (acc) begin
          m_full = 1'b1; m_taken = ref_cond(code, eff); m_target = bus.cond_target;
          $display("txn rand %0d: code=%0d flags=%b target=%h taken=%b", n, code, eff, m_target, m_taken);
        end else if (m_full && bus.jump_ready) begin
          m_full = 1'b0;
        end
        m_flags = eff;
      end
      tick();
      total++;
      if (flags !== m_flags || bus.jump_valid !== m_full) begin
        bad++; $display("FAIL rand_state%0d: actual flags=%b valid=%b required flags=%b valid=%b",
                        n, flags, bus.jump_valid, m_flags, m_full);
      end
      if (m_full) begin
        total++;
        if (bus.jump_taken !== m_taken || bus.jump_target !== m_target) begin
          bad++; $display("FAIL rand_decision%0d: actual taken=%b target=%h required taken=%b target=%h",
                          n, bus.jump_taken, bus.jump_target, m_taken, m_target);
        end
      end
    end
    drive_idle();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive_idle();
    test_reset();
    test_bypass();
    test_signed();
    test_backpressure();
    test_back_to_back();
`ifdef FLAG_SHADOW_EN
    test_shadow();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flag_cond_unit.md
Name: flag_cond_unit

Overview:
- Consumer end of the arithmetic ALU's flag interface.
- Latches the ALU's O, C, S and Z flags into an architectural flag register.
- Evaluates branch/jump condition codes against those flags.
- Hands a registered taken/not-taken decision plus target to the fetch stage over a valid/ready handshake.
- Sits between the execute stage (ALU flags) and the PC/fetch logic.

Parameters:
- ADDR_BITS, 16, width of the jump target carried with each condition request.
- COND_BITS, 4, width of the condition code field; fixed at 4, other values unsupported.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_o  in  1  ALU overflow flag.
- alu_c  in  1  ALU carry-out flag.
- alu_s  in  1  ALU sign flag.
- alu_z  in  1  ALU zero flag.
- flag_we  in  1  write alu_* into the flag register this cycle.
- cond_valid  in  1  a condition request is presented.
- cond_code  in  COND_BITS  condition to evaluate.
- cond_target  in  ADDR_BITS  jump target carried with the request.
- cond_ready  out  1  the unit accepts a request this cycle.
- jump_valid  out  1  a decision is held on the jump_* outputs.
- jump_taken  out  1  the condition evaluated true.
- jump_target  out  ADDR_BITS  target captured with the request.
- jump_ready  in  1  fetch consumes the decision.
- flags  out  4  current flag register, ordered {O,C,S,Z}.

Behaviour:
- Reset (synchronous, active-high, on the clk edge):
  - flags=0, jump_valid=0, jump_taken=0, jump_target=0; FSM goes to EMPTY.
  - Reset overrides every other input in that cycle.
  - Reset mid-handshake discards the held decision; no decision is lost silently, because jump_valid drops.
- Flag register:
  - On flag_we, flags <= {alu_o, alu_c, alu_s, alu_z}; otherwise it holds.
- Bypass:
  - When flag_we and an accepted request occur in the same cycle, evaluation uses the incoming alu_* values, not the stale register.
- FSM has two states, EMPTY and FULL.
  - cond_ready = (state==EMPTY) | jump_ready; it is combinational from state and jump_ready only, with no dependence on cond_valid.
  - Accept = cond_valid & cond_ready.
  - EMPTY + accept: register the decision; next state is FULL with jump_valid=1.
  - FULL + jump_ready + accept: load the new decision and stay FULL. This gives back-to-back throughput of 1 per cycle.
  - FULL + jump_ready + no accept: go to EMPTY with jump_valid=0.
  - FULL + no jump_ready: hold jump_taken and jump_target stable.
- Latency: decision appears 1 cycle after accept.
- Condition codes (E = effective flags):
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 C
  - 4 !C
  - 5 S
  - 6 !S
  - 7 O
  - 8 !O
  - 9 S^O (signed LT)
  - 10 !(S^O) (signed GE)
  - 11 (S^O)|Z (signed LE)
  - 12 !((S^O)|Z) (signed GT)
  - 13 C&!Z
  - 14 !C|Z
  - 15 never
- All 16 codes are defined, so there is no illegal-code path.

Optional Feature:
- Macro: FLAG_SHADOW_EN.
- With the macro defined:
  - Adds inputs flag_save (1) and flag_restore (1), plus an internal 4-bit shadow register that resets to 0.
  - flag_save: shadow <= flags (pre-update value).
  - flag_restore: flags <= shadow.
  - Flag register priority: reset > flag_restore > flag_we.
  - Save and restore in the same cycle swap the flag register and the shadow.
  - The bypass path uses the restored value when restore and accept coincide.
- Without the macro: the ports and shadow register are absent, and behaviour is exactly as above.

Decomposition:
- Package flag_cond_pkg:
  - cond_e enum holding the 16 codes above.
  - Flag bit index constants FLAG_O=3, FLAG_C=2, FLAG_S=1, FLAG_Z=0.
  - flags_t packed struct {o,c,s,z}.
- Sub-module flag_cond_eval: purely combinational (flags_t, cond_e) -> taken. It is reused by the conditional-move logic.

Test Plan:
- Reset check: hold reset 2 cycles with cond_valid=1 and flag_we=1 -> flags=0000, jump_valid=0, cond_ready=1 after release.
- Bypass: flags=0000; same cycle flag_we=1 with alu_z=1, cond_valid=1, code=1, target=16'h0040 -> next cycle jump_valid=1, taken=1, target=0040, flags=0001.
- Signed compare: load O=1, S=0 -> code 9 taken=1, code 10 taken=0, code 12 taken=0; load Z=1, S=O=0 -> code 11 taken=1.
- Backpressure: jump_ready=0 for 3 cycles after a decision -> cond_ready=0 and outputs stable. Then jump_ready=1 with a new request -> new decision next cycle, jump_valid never drops.
- Stream: 8 consecutive requests with jump_ready=1, codes 0 and 15 alternating -> 8 decisions on consecutive cycles, taken=1,0,1,0...
- FLAG_SHADOW_EN: flags=1010, save; load 0101; restore -> flags=1010. Save and restore in the same cycle -> flags and shadow swapped.
